pulse_period_meter: RTL and testbench

- Receive side of the counter/strobe interface: takes a one-cycle strobe stream (e.g. the terminal-count output of a mod-N counter) and measures the number of clk cycles between consecutive strobes.
- Each completed period is presented on a valid/ready output port.
- Sits between strobe generators and the status/display logic.
- Flags saturation (period too long) and lost results (consumer too slow).

---
 rtl/pulse_period_meter.sv | 105 ++++++++++
 tb/tb_pulse_period_meter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/pulse_period_meter.sv
// pulse_period_meter: measures the number of clk cycles between consecutive
// one-cycle strobes on tick and presents each completed period on a
// valid/ready port. Saturated periods set the sticky ovf flag; results that
// arrive while an earlier one is still pending are dropped and set lost.
module pulse_period_meter #(
    parameter int MAX_PERIOD = 65535,
    parameter int BITS       = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            clr,
    input  logic            tick,
    input  logic            ready,
    output logic [BITS-1:0] period,
    output logic            valid,
    output logic            ovf,
    output logic            lost,
    output logic            busy
);

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    localparam logic [BITS-1:0] MAX_VAL = BITS'(MAX_PERIOD);
    localparam logic [BITS-1:0] ONE     = BITS'(1);

    state_t          state;
    logic [BITS-1:0] cnt;

    // A new result may be stored when the output slot is empty or is being
    // transferred on this very edge.
    logic accept;
    assign accept = !valid || ready;

    // Measurement FSM with registered outputs; rst is asynchronous active-low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            cnt    <= '0;
            period <= '0;
            valid  <= 1'b0;
            ovf    <= 1'b0;
            lost   <= 1'b0;
            busy   <= 1'b0;
        end else if (clr) begin
            state  <= IDLE;
            cnt    <= '0;
            period <= '0;
            valid  <= 1'b0;
            ovf    <= 1'b0;
            lost   <= 1'b0;
            busy   <= 1'b0;
        end else begin
            // Completed handshake empties the slot unless a new result lands
            // on the same edge (the assignment further down then wins).
            if (valid && ready) begin
                valid <= 1'b0;
            end

            if (!en) begin
                // Abort any measurement in progress; results and flags stay.
                state <= IDLE;
                cnt   <= '0;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (tick) begin
                            // First strobe only arms the meter.
                            state <= MEASURE;
                            cnt   <= ONE;
                            busy  <= 1'b1;
                        end
                    end
                    MEASURE: begin
                        if (tick) begin
                            // Period end; restart immediately for the next one.
                            cnt <= ONE;
                            if (cnt == MAX_VAL) begin
                                ovf <= 1'b1;
                            end
                            if (accept) begin
                                period <= cnt;
                                valid  <= 1'b1;
                            end else begin
                                lost <= 1'b1;
                            end
                        end else if (cnt != MAX_VAL) begin
                            cnt <= cnt + ONE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pulse_period_meter.sv
// Randomised and directed bench for pulse_period_meter. A reference model
// works from strobe timestamps (period = cycle difference, clipped at the
// maximum) and pushes every stored result into a queue; a monitor on the
// falling edge compares the DUT outputs and pops results as they transfer.
module tb_pulse_period_meter;

    localparam int BITS       = 4;
    localparam int MAX_PERIOD = 15;

    logic            clk = 1'b0;
    logic            rst;
    logic            en;
    logic            clr;
    logic            tick;
    logic            ready;
    logic [BITS-1:0] period;
    logic            valid;
    logic            ovf;
    logic            lost;
    logic            busy;

    pulse_period_meter #(
        .MAX_PERIOD(MAX_PERIOD),
        .BITS      (BITS)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .clr   (clr),
        .tick  (tick),
        .ready (ready),
        .period(period),
        .valid (valid),
        .ovf   (ovf),
        .lost  (lost),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int q[$];
    int cyc        = 0;
    int last_tick  = 0;
    bit armed      = 0;
    bit pending    = 0;
    bit m_ovf      = 0;
    bit m_lost     = 0;
    int exp_period = 0;

    always @(posedge clk or negedge rst) begin
        int res;
        bit p0;
        if (!rst) begin
            armed = 0; pending = 0; m_ovf = 0; m_lost = 0; exp_period = 0;
            q.delete();
        end else begin
            cyc++;
            if (clr) begin
                armed = 0; pending = 0; m_ovf = 0; m_lost = 0; exp_period = 0;
                q.delete();
            end else begin
                p0 = pending;
                if (p0 && ready) pending = 0;
                if (!en) begin
                    armed = 0;
                end else if (tick) begin
                    if (armed) begin
                        res = cyc - last_tick;
                        if (res >= MAX_PERIOD) begin
                            res   = MAX_PERIOD;
                            m_ovf = 1;
                        end
                        if (!p0 || ready) begin
                            q.push_back(res);
                            pending    = 1;
                            exp_period = res;
                        end else begin
                            m_lost = 1;
                        end
                    end
                    armed     = 1;
                    last_tick = cyc;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst) begin
            chk("valid", int'(valid), int'(pending));
            chk("busy", int'(busy), int'(armed));
            chk("ovf", int'(ovf), int'(m_ovf));
            chk("lost", int'(lost), int'(m_lost));
            chk("period", int'(period), exp_period);
            if (valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_result", int'(period), -1);
                end else begin
                    chk("xfer_period", int'(period), q[0]);
                    if (ready) void'(q.pop_front());
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic t);
        tick = t;
        @(posedge clk);
        #1;
        tick = 1'b0;
        $display("cyc=%0d en=%0b tick=%0b ready=%0b clr=%0b -> valid=%0b period=%0d ovf=%0b lost=%0b busy=%0b",
                 cyc, en, t, ready, clr, valid, period, ovf, lost, busy);
    endtask

    task automatic gap(input int n);
        repeat (n - 1) step(1'b0);
        step(1'b1);
    endtask

    task automatic check_all_zero(input string name);
        chk({name, "_period"}, int'(period), 0);
        chk({name, "_valid"}, int'(valid), 0);
        chk({name, "_ovf"}, int'(ovf), 0);
        chk({name, "_lost"}, int'(lost), 0);
        chk({name, "_busy"}, int'(busy), 0);
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; clr = 1'b0; tick = 1'b0; ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b1;

        // Tick every 5 cycles: one arming tick, then period 5 results.
        en = 1'b1; ready = 1'b1;
        step(1'b1);
        repeat (4) gap(5);

        // Back-to-back periods 1 and 3.
        gap(1);
        gap(3);

        // Saturation, then a normal period with ovf still set, then clr.
        gap(40);
        gap(6);
        clr = 1'b1; step(1'b0); clr = 1'b0;

        // Slow consumer: second result lost, then one-cycle ready.
        ready = 1'b0;
        step(1'b1);
        gap(4);
        gap(4);
        step(1'b0);
        ready = 1'b1; step(1'b0);
        ready = 1'b0; step(1'b0); step(1'b0);

        // Abort by dropping en, re-arm, then period 3.
        ready = 1'b1;
        step(1'b1);
        step(1'b0); step(1'b0);
        en = 1'b0; step(1'b0); step(1'b0);
        en = 1'b1; step(1'b0);
        step(1'b1);
        gap(3);

        // Asynchronous reset mid-period with a pending result.
        ready = 1'b0;
        gap(3);
        step(1'b0);
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(posedge clk);
        #1;
        rst = 1'b1;
        ready = 1'b1;
        step(1'b1);
        gap(3);

        // Randomised traffic.
        for (int i = 0; i < 600; i++) begin
            clr   = ($urandom_range(0, 49) == 0);
            en    = ($urandom_range(0, 15) != 0);
            ready = $urandom_range(0, 1);
            step($urandom_range(0, 2) == 0);
            clr = 1'b0;
        end

        // Drain: every stored result must have been transferred.
        en = 1'b0; ready = 1'b1;
        repeat (3) step(1'b0);
        chk("queue_drained", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
